// File: rtl/wavetable_pkg.sv
// wavetable_pkg: shared types, default widths and saturation helper for wavetable_voice_bank.
package wavetable_pkg;
   localparam int PHASE_W = 22;
   localparam int INC_W_DEF = 24;
   typedef enum logic [1:0] {NOTE_ON = 2'd0, NOTE_OFF = 2'd1, SET_INC = 2'd2, NOP = 2'd3} voice_op_e;
   typedef enum logic [2:0] {IDLE, RD0, RD1, CALC, ADV, DONE} fsm_state_e;
   typedef struct packed {
      logic [PHASE_W-1:0] phase;
      logic [INC_W_DEF-1:0] inc;
      logic loop;
      logic active;
   } voice_t;
   function automatic logic signed [31:0] sat(input logic signed [31:0] a, input int w);
      logic signed [31:0] hi;
      hi = (32'sd1 <<< (w - 1)) - 32'sd1;
      return a > hi ? hi : (a < -hi - 32'sd1 ? -hi - 32'sd1 : a);
   endfunction
endpackage

// File: rtl/wavetable_voice_bank_linear_interp.sv
// linear_interp: s0 + ((s1-s0)*frac >>> FRAC_BITS), rounding toward -inf.
module linear_interp #(
   parameter int SAMPLE_W = 16,
   parameter int FRAC_BITS = 16
) (
   input  logic signed [SAMPLE_W-1:0] s0,
   input  logic signed [SAMPLE_W-1:0] s1,
   input  logic [FRAC_BITS-1:0] frac,
   output logic signed [SAMPLE_W-1:0] lerp
);
   localparam int PRW = SAMPLE_W + FRAC_BITS + 2;
   logic signed [SAMPLE_W:0] diff;
   logic signed [PRW-1:0] prod;
   assign diff = (SAMPLE_W + 1)'(s1) - (SAMPLE_W + 1)'(s0);
   assign prod = PRW'(diff) * PRW'($signed({1'b0, frac}));
   assign lerp = s0 + SAMPLE_W'(prod >>> FRAC_BITS);
endmodule

// File: rtl/wavetable_voice_bank.sv
// wavetable_voice_bank: time-multiplexed wavetable voices summed into one saturated sample per tick.
// LINEAR_INTERP_EN adds the RD1 slot and linear interpolation; otherwise nearest-lower sample.
module wavetable_voice_bank
   import wavetable_pkg::*;
#(
   parameter int NUM_VOICES = 4,
   parameter int CLIP_LEN = 64,
   parameter int SAMPLE_W = 16,
   parameter int FRAC_BITS = 16,
   parameter int INC_W = 24
) (
   input  logic mclk,
   input  logic rst,
   input  logic sample_tick,
   input  logic cmd_valid,
   output logic cmd_ready,
   input  logic [$clog2(NUM_VOICES)-1:0] cmd_voice,
   input  logic [1:0] cmd_op,
   input  logic [INC_W-1:0] cmd_inc,
   input  logic cmd_loop,
   output logic [$clog2(CLIP_LEN)-1:0] mem_addr,
   input  logic signed [SAMPLE_W-1:0] mem_rdata,
   output logic signed [SAMPLE_W-1:0] mix_sample,
   output logic mix_valid,
   output logic [NUM_VOICES-1:0] voice_active,
   output logic overrun
);
   localparam int IW = $clog2(CLIP_LEN);
   localparam int VW = $clog2(NUM_VOICES);
   localparam int AW = SAMPLE_W + VW + 1;
   localparam int SW = (PHASE_W > INC_W_DEF ? PHASE_W : INC_W_DEF) + 1;
   fsm_state_e state, state_n;
   voice_t voices [NUM_VOICES];
   voice_t cv;
   logic [VW-1:0] v;
   logic [IW-1:0] idx;
   logic [SW-1:0] sum;
   logic signed [AW-1:0] acc, cx;
   logic signed [SAMPLE_W-1:0] contrib;
   logic last;
   assign cv = voices[v];
   assign idx = cv.phase[PHASE_W-1:FRAC_BITS];
   assign last = v == VW'(NUM_VOICES - 1);
   assign sum = SW'(cv.phase) + SW'(cv.inc);
   assign cx = AW'(contrib);
   assign cmd_ready = state == IDLE && !sample_tick && !rst;
   for (genvar g = 0; g < NUM_VOICES; g++) begin : g_act
      assign voice_active[g] = voices[g].active;
   end
`ifdef LINEAR_INTERP_EN
   localparam fsm_state_e AFTER_RD0 = RD1;
   logic signed [SAMPLE_W-1:0] s0, lerp;
   logic [IW-1:0] nidx;
   // one-shot voices clamp the upper neighbour at the clip end instead of wrapping
   assign nidx = (cv.loop || !(&idx)) ? idx + IW'(1) : idx;
   assign mem_addr = rst ? '0 : state == RD0 ? idx : state == RD1 ? nidx : '0;
   assign contrib = lerp;
   linear_interp #(.SAMPLE_W(SAMPLE_W), .FRAC_BITS(FRAC_BITS)) u_interp (
      .s0(s0),
      .s1(mem_rdata),
      .frac(cv.phase[FRAC_BITS-1:0]),
      .lerp(lerp)
   );
`else
   localparam fsm_state_e AFTER_RD0 = CALC;
   assign mem_addr = rst ? '0 : state == RD0 ? idx : '0;
   assign contrib = mem_rdata;
`endif
   always_ff @(posedge mclk) begin
      if (rst) state <= IDLE;
      else state <= state_n;
   end
   always_comb begin
      state_n = state;
      case (state)
         IDLE: state_n = sample_tick ? RD0 : IDLE;
         RD0: state_n = AFTER_RD0;
         RD1: state_n = CALC;
         CALC: state_n = ADV;
         ADV: state_n = last ? DONE : RD0;
         default: state_n = IDLE;
      endcase
   end
   always_ff @(posedge mclk) begin
      if (rst) begin
         for (int i = 0; i < NUM_VOICES; i++) voices[i] <= '0;
         acc <= '0;
         v <= '0;
         mix_sample <= '0;
         mix_valid <= 1'b0;
         overrun <= 1'b0;
`ifdef LINEAR_INTERP_EN
         s0 <= '0;
`endif
      end else begin
         mix_valid <= state == ADV && last;
         if (sample_tick && state != IDLE) overrun <= 1'b1;
         if (state == IDLE) v <= '0;
         if (cmd_valid && cmd_ready) begin
            case (voice_op_e'(cmd_op))
               NOTE_ON: voices[cmd_voice] <= '{phase: '0, inc: INC_W_DEF'(cmd_inc), loop: cmd_loop, active: 1'b1};
               NOTE_OFF: voices[cmd_voice].active <= 1'b0;
               SET_INC: voices[cmd_voice].inc <= INC_W_DEF'(cmd_inc);
               default: ;
            endcase
         end
`ifdef LINEAR_INTERP_EN
         if (state == RD1) s0 <= mem_rdata;
`endif
         if (state == CALC && cv.active) acc <= acc + cx;
         if (state == ADV) begin
            v <= v + VW'(1);
            // a one-shot voice that runs off the clip end stops and rewinds
            if (cv.active && !cv.loop && |sum[SW-1:PHASE_W]) begin
               voices[v].phase <= '0;
               voices[v].active <= 1'b0;
            end else if (cv.active) voices[v].phase <= sum[PHASE_W-1:0];
            if (last) mix_sample <= SAMPLE_W'(sat(32'(acc), SAMPLE_W));
         end
         if (state == DONE) acc <= '0;
      end
   end
endmodule
